p09_brick_mem_arbiter: RTL

Shares the single-port synchronous brick RAM of the breakout game between the pixel renderer and two game-logic requesters: ball collision and brick clear. The renderer has absolute priority. Game requesters are served round-robin, and only outside active video. After reset, or on a level start, the block sweeps the RAM to initialise every brick before allowing any access. It sits between the VGA timing generator (`active`) and the brick RAM macro.

---
 rtl/p09_brick_mem_arbiter_pkg.sv | 18 +
 rtl/p09_brick_mem_arbiter_if.sv | 40 ++++
 rtl/p09_brick_mem_arbiter_rr_arb2.sv | 35 +++
 rtl/p09_brick_mem_arbiter.sv | 90 +++++++++
 4 files changed

// File: rtl/p09_brick_mem_arbiter_pkg.sv
// Shared breakout definitions: default brick RAM geometry, arbiter state
// encoding and game requester indices.
package p09_breakout_pkg;

   localparam int             DEF_ADDR_W   = 6;
   localparam int             DEF_DATA_W   = 4;
   localparam logic [3:0]     DEF_INIT_VAL = 4'hF;

   localparam int N_REQ     = 2;
   localparam int REQ_BALL  = 0;
   localparam int REQ_CLEAR = 1;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/p09_brick_mem_arbiter_if.sv
// Brick RAM bus: renderer read port, two game request ports and the RAM macro
// side; slave is the arbiter view, master is the clients/RAM view.
interface p09_brick_mem_arbiter_if
   import p09_breakout_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic                  ren_req;
   logic [ADDR_W-1:0]     ren_addr;
   logic                  ren_valid;
   logic [DATA_W-1:0]     ren_rdata;

   logic [N_REQ-1:0]        gm_req;
   logic [N_REQ-1:0]        gm_we;
   logic [N_REQ*ADDR_W-1:0] gm_addr;
   logic [N_REQ*DATA_W-1:0] gm_wdata;
   logic [N_REQ-1:0]        gm_gnt;
   logic [N_REQ-1:0]        gm_rvalid;
   logic [DATA_W-1:0]       gm_rdata;

   logic [ADDR_W-1:0]     mem_addr;
   logic                  mem_we;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W-1:0]     mem_rdata;

   modport slave (
      input  ren_req, ren_addr, gm_req, gm_we, gm_addr, gm_wdata, mem_rdata,
      output ren_valid, ren_rdata, gm_gnt, gm_rvalid, gm_rdata,
             mem_addr, mem_we, mem_wdata
   );

   modport master (
      output ren_req, ren_addr, gm_req, gm_we, gm_addr, gm_wdata, mem_rdata,
      input  ren_valid, ren_rdata, gm_gnt, gm_rvalid, gm_rdata,
             mem_addr, mem_we, mem_wdata
   );

endinterface

// File: rtl/p09_brick_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant when enabled; the
// pointer moves to the other requester after each grant, no backpressure.
module p09_rr_arb2
   import p09_breakout_pkg::*;
(
   input  logic             clk,
   input  logic             nRst,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt
);

   logic rr;

   always_comb begin
      gnt = '0;
      if (en) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr ? 2'b10 : 2'b01;
            default: gnt = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         rr <= 1'b0;
      end else if (|gnt) begin
         rr <= gnt[REQ_BALL];
      end
   end

endmodule

// File: rtl/p09_brick_mem_arbiter.sv
// Brick RAM arbiter: init sweep, then renderer-first / round-robin game access.
// Access registered 1 edge after request, read valid 2 edges; losers simply wait.
module p09_brick_mem_arbiter
   import p09_breakout_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                DATA_W   = DEF_DATA_W,
   parameter logic [DATA_W-1:0] INIT_VAL = DEF_INIT_VAL
)(
   input  logic clk,
   input  logic nRst,
   input  logic active,
   input  logic level_start,
   output logic busy,
   p09_brick_mem_arbiter_if.slave bus
);

   state_t            state;
   logic [ADDR_W:0]   cnt;
   logic              ren_issue;
   logic [N_REQ-1:0]  gm_rd_issue;
   logic              arb_en;
   logic [N_REQ-1:0]  arb_gnt;
   logic              gsel;

   // Game traffic only when the renderer is idle and the beam is in blanking.
   assign arb_en = (state == ST_RUN) && !level_start && !bus.ren_req && !active;
   assign gsel   = arb_gnt[REQ_CLEAR];

   assign bus.ren_rdata = bus.mem_rdata;
   assign bus.gm_rdata  = bus.mem_rdata;

   p09_rr_arb2 u_arb (
      .clk  (clk),
      .nRst (nRst),
      .en   (arb_en),
      .req  (bus.gm_req),
      .gnt  (arb_gnt)
   );

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state         <= ST_INIT;
         cnt           <= '0;
         busy          <= 1'b1;
         bus.mem_addr  <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_wdata <= '0;
         bus.gm_gnt    <= '0;
         bus.gm_rvalid <= '0;
         bus.ren_valid <= 1'b0;
         ren_issue     <= 1'b0;
         gm_rd_issue   <= '0;
      end else begin
         // Read valids trail their issue by one edge, even across a level restart.
         bus.ren_valid <= ren_issue;
         bus.gm_rvalid <= gm_rd_issue;
         ren_issue     <= 1'b0;
         gm_rd_issue   <= '0;
         bus.gm_gnt    <= '0;
         bus.mem_we    <= 1'b0;

         if (level_start) begin
            state <= ST_INIT;
            cnt   <= '0;
            busy  <= 1'b1;
         end else if (state == ST_INIT) begin
            if (cnt[ADDR_W]) begin
               state <= ST_RUN;
               busy  <= 1'b0;
            end else begin
               bus.mem_we    <= 1'b1;
               bus.mem_addr  <= cnt[ADDR_W-1:0];
               bus.mem_wdata <= INIT_VAL;
               cnt           <= cnt + 1'b1;
            end
         end else if (bus.ren_req) begin
            bus.mem_addr <= bus.ren_addr;
            ren_issue    <= 1'b1;
         end else if (|arb_gnt) begin
            bus.gm_gnt    <= arb_gnt;
            bus.mem_addr  <= bus.gm_addr[int'(gsel)*ADDR_W +: ADDR_W];
            bus.mem_we    <= bus.gm_we[gsel];
            bus.mem_wdata <= bus.gm_wdata[int'(gsel)*DATA_W +: DATA_W];
            gm_rd_issue   <= arb_gnt & ~bus.gm_we;
         end
      end
   end

endmodule
